// File: rtl/row_mover_pkg.sv
// blockstacker_pkg: playfield geometry and row FSM states shared by row_mover and the level controller.
package blockstacker_pkg;
    localparam int ROW_W = 16;
    localparam int SPD_W = 6;
    typedef enum logic [1:0] {IDLE, MOVE, JUDGE, REPORT} state_t;
endpackage

// File: rtl/row_mover_if.sv
// row_mover_if: control inputs and row status outputs of the row mover.
interface row_mover_if #(
    parameter int ROW_W = blockstacker_pkg::ROW_W,
    parameter int SPD_W = blockstacker_pkg::SPD_W
);
    logic             frame_tick;
    logic             start;
    logic             stop;
    logic             first_row;
    logic [SPD_W-1:0] speed_count;
    logic [3:0]       num_blocks;
    logic [ROW_W-1:0] row_mask;
    logic             next_signal;
    logic             fail;
    logic             busy;
    logic [3:0]       kept_blocks;
    modport master (
        output frame_tick, start, stop, first_row, speed_count, num_blocks,
        input  row_mask, next_signal, fail, busy, kept_blocks
    );
    modport slave (
        input  frame_tick, start, stop, first_row, speed_count, num_blocks,
        output row_mask, next_signal, fail, busy, kept_blocks
    );
endinterface

// File: rtl/row_mover_step_divider.sv
// step_divider: counts frame ticks and emits a step pulse every speed_i ticks.
module step_divider #(
    parameter int SPD_W = blockstacker_pkg::SPD_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [SPD_W-1:0] speed_i,
    output logic             step_o
);
    logic [SPD_W-1:0] cnt_q, cnt_d;
    always_comb begin
        step_o = tick_i && (cnt_q + SPD_W'(1) == speed_i);
        cnt_d  = clear_i ? '0 : step_o ? '0 : tick_i ? cnt_q + SPD_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/row_mover.sv
// row_mover: bounces a block across one playfield row, freezes it on stop and
// judges its overlap with the previous row.
module row_mover #(
    parameter int ROW_W = blockstacker_pkg::ROW_W,
    parameter int SPD_W = blockstacker_pkg::SPD_W
) (
    input logic       clk,
    input logic       resetn,
    row_mover_if.slave bus
);
    import blockstacker_pkg::*;
    localparam int PW = $clog2(ROW_W);
    localparam int WW = $clog2(ROW_W + 1);
    state_t           state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [WW-1:0]    width_q, width_d;
    logic [SPD_W-1:0] speed_q, speed_d;
    logic [ROW_W-1:0] prev_q, prev_d, overlap;
    logic [3:0]       kept_q, kept_d;
    logic             step, at_edge;
    // stop wins over a same-cycle frame_tick, so the divider never sees that tick
    step_divider #(.SPD_W(SPD_W)) u_div (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (state_q != MOVE),
        .tick_i  (state_q == MOVE && bus.frame_tick && !bus.stop),
        .speed_i (speed_q),
        .step_o  (step)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE && bus.start) ? MOVE :
                  (state_q == MOVE && bus.stop)  ? JUDGE :
                  (state_q == JUDGE)             ? REPORT :
                  (state_q == REPORT)            ? IDLE : state_q;
    end
    always_comb begin
        bus.row_mask    = (state_q == IDLE) ? '0 : ROW_W'(~({ROW_W{1'b1}} << width_q)) << pos_q;
        bus.busy        = state_q != IDLE;
        bus.next_signal = state_q == REPORT && kept_q != '0;
        bus.fail        = state_q == REPORT && kept_q == '0;
        bus.kept_blocks = kept_q;
    end
    assign overlap = bus.row_mask & prev_q;
    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        width_d = width_q;
        speed_d = speed_q;
        prev_d  = prev_q;
        kept_d  = kept_q;
        at_edge = dir_q ? (pos_q == '0) : (32'(pos_q) == ROW_W - 32'(width_q));
        if (state_q == IDLE && bus.start) begin
            width_d = (bus.num_blocks == '0) ? WW'(1) :
                      (32'(bus.num_blocks) > ROW_W) ? WW'(ROW_W) : WW'(bus.num_blocks);
            speed_d = (bus.speed_count == '0) ? SPD_W'(1) : bus.speed_count;
            pos_d   = '0;
            dir_d   = 1'b0;
            prev_d  = bus.first_row ? '1 : prev_q;
        end
        // dir 0 moves right; hitting an edge reverses and steps back inward
        if (step && 32'(width_q) != ROW_W) begin
            dir_d = at_edge ? ~dir_q : dir_q;
            pos_d = (dir_q ^ at_edge) ? pos_q - PW'(1) : pos_q + PW'(1);
        end
        if (state_q == JUDGE)  kept_d = 4'($countones(overlap));
        if (state_q == REPORT) prev_d = (kept_q != '0) ? overlap : '1;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_q   <= '0;
            dir_q   <= 1'b0;
            width_q <= WW'(1);
            speed_q <= SPD_W'(1);
            prev_q  <= '1;
            kept_q  <= '0;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            width_q <= width_d;
            speed_q <= speed_d;
            prev_q  <= prev_d;
            kept_q  <= kept_d;
        end
    end
endmodule

// File: tb/tb_row_mover.sv
// tb_row_mover: directed scenarios for row_mover with hand-computed expected masks and pulses.
module tb_row_mover;
    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad = 0;
    row_mover_if bus();
    row_mover dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic pulse_start(input logic [3:0] nb, input logic [5:0] sc, input logic fr);
        bus.num_blocks = nb; bus.speed_count = sc; bus.first_row = fr; bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic ticks(input int n);
        bus.frame_tick = 1'b1;
        cyc(n);
        bus.frame_tick = 1'b0;
    endtask

    // stop in cycle N: JUDGE in N+1, REPORT pulse in N+2, IDLE after
    task automatic do_stop(input string name, input logic tick, input logic [15:0] m, input logic [3:0] k);
        bus.stop = 1'b1; bus.frame_tick = tick;
        cyc(1);
        bus.stop = 1'b0; bus.frame_tick = 1'b0;
        total++;
        if (bus.row_mask !== m || bus.next_signal !== 1'b0 || bus.fail !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_judge mask=%h ns=%b fail=%b busy=%b required mask=%h ns=0 fail=0 busy=1",
                     name, bus.row_mask, bus.next_signal, bus.fail, bus.busy, m);
        end
        cyc(1);
        total++;
        if (bus.kept_blocks !== k || bus.next_signal !== (k != 0) || bus.fail !== (k == 0) || bus.row_mask !== m) begin
            bad++;
            $display("FAIL %s_report kept=%0d ns=%b fail=%b mask=%h required kept=%0d ns=%b fail=%b mask=%h",
                     name, bus.kept_blocks, bus.next_signal, bus.fail, bus.row_mask, k, k != 0, k == 0, m);
        end
        cyc(1);
        total++;
        if (bus.row_mask !== 16'h0 || bus.busy !== 1'b0 || bus.next_signal !== 1'b0 || bus.fail !== 1'b0 || bus.kept_blocks !== k) begin
            bad++;
            $display("FAIL %s_idle mask=%h busy=%b ns=%b fail=%b kept=%0d required mask=0 busy=0 ns=0 fail=0 kept=%0d",
                     name, bus.row_mask, bus.busy, bus.next_signal, bus.fail, bus.kept_blocks, k);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        total++;
        if (bus.row_mask !== 16'h0 || bus.busy !== 1'b0 || bus.next_signal !== 1'b0 || bus.fail !== 1'b0 || bus.kept_blocks !== 4'd0) begin
            bad++;
            $display("FAIL reset_async mask=%h busy=%b ns=%b fail=%b kept=%0d required all zero",
                     bus.row_mask, bus.busy, bus.next_signal, bus.fail, bus.kept_blocks);
        end
        cyc(2);
        resetn = 1'b1;
        cyc(1);
        total++;
        if (bus.row_mask !== 16'h0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release mask=%h busy=%b required mask=0 busy=0", bus.row_mask, bus.busy);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        pulse_start(4'd3, 6'd1, 1'b1);
        total++;
        if (bus.row_mask !== 16'h0007 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL bounce_start mask=%h busy=%b required mask=0007 busy=1", bus.row_mask, bus.busy);
        end
        ticks(12);
        total++;
        if (bus.row_mask !== 16'h7000) begin bad++; $display("FAIL bounce_pos12 mask=%h required=7000", bus.row_mask); end
        ticks(1);
        total++;
        if (bus.row_mask !== 16'hE000) begin bad++; $display("FAIL bounce_pos13 mask=%h required=e000", bus.row_mask); end
        ticks(1);
        total++;
        if (bus.row_mask !== 16'h7000) begin bad++; $display("FAIL bounce_back mask=%h required=7000", bus.row_mask); end
        do_stop("bounce", 1'b0, 16'h7000, 4'd3);
    endtask

    task automatic test_speed();
        apply_reset();
        pulse_start(4'd3, 6'd4, 1'b1);
        ticks(3);
        total++;
        if (bus.row_mask !== 16'h0007) begin bad++; $display("FAIL speed_3ticks mask=%h required=0007", bus.row_mask); end
        ticks(1);
        total++;
        if (bus.row_mask !== 16'h000E) begin bad++; $display("FAIL speed_4ticks mask=%h required=000e", bus.row_mask); end
        pulse_start(4'd5, 6'd1, 1'b0);
        total++;
        if (bus.row_mask !== 16'h000E) begin bad++; $display("FAIL start_in_move mask=%h required=000e", bus.row_mask); end
        ticks(4);
        total++;
        if (bus.row_mask !== 16'h001C) begin bad++; $display("FAIL speed_8ticks mask=%h required=001c", bus.row_mask); end
        do_stop("speed", 1'b0, 16'h001C, 4'd3);
    endtask

    task automatic test_keep();
        apply_reset();
        pulse_start(4'd4, 6'd1, 1'b1);
        do_stop("keep_seed", 1'b0, 16'h000F, 4'd4);
        pulse_start(4'd3, 6'd1, 1'b0);
        ticks(2);
        total++;
        if (bus.row_mask !== 16'h001C) begin bad++; $display("FAIL keep_pos2 mask=%h required=001c", bus.row_mask); end
        do_stop("keep", 1'b0, 16'h001C, 4'd2);
        pulse_start(4'd4, 6'd1, 1'b0);
        do_stop("keep_prev", 1'b0, 16'h000F, 4'd2);
    endtask

    task automatic test_fail();
        apply_reset();
        pulse_start(4'd2, 6'd1, 1'b1);
        do_stop("fail_seed", 1'b0, 16'h0003, 4'd2);
        pulse_start(4'd3, 6'd1, 1'b0);
        ticks(5);
        total++;
        if (bus.row_mask !== 16'h00E0) begin bad++; $display("FAIL fail_pos5 mask=%h required=00e0", bus.row_mask); end
        do_stop("fail", 1'b0, 16'h00E0, 4'd0);
        pulse_start(4'd1, 6'd1, 1'b0);
        ticks(9);
        total++;
        if (bus.row_mask !== 16'h0200) begin bad++; $display("FAIL fail_pos9 mask=%h required=0200", bus.row_mask); end
        do_stop("fail_prev", 1'b0, 16'h0200, 4'd1);
    endtask

    task automatic test_stop_clamp();
        apply_reset();
        pulse_start(4'd2, 6'd2, 1'b1);
        ticks(1);
        total++;
        if (bus.row_mask !== 16'h0003) begin bad++; $display("FAIL prio_pre mask=%h required=0003", bus.row_mask); end
        do_stop("stop_prio", 1'b1, 16'h0003, 4'd2);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.row_mask !== 16'h0) begin
            bad++; $display("FAIL stop_in_idle busy=%b mask=%h required busy=0 mask=0", bus.busy, bus.row_mask);
        end
        pulse_start(4'd0, 6'd0, 1'b1);
        total++;
        if (bus.row_mask !== 16'h0001) begin bad++; $display("FAIL clamp_lo mask=%h required=0001", bus.row_mask); end
        ticks(1);
        total++;
        if (bus.row_mask !== 16'h0002) begin bad++; $display("FAIL clamp_speed0 mask=%h required=0002", bus.row_mask); end
        do_stop("clamp_lo", 1'b0, 16'h0002, 4'd1);
        pulse_start(4'd15, 6'd1, 1'b1);
        total++;
        if (bus.row_mask !== 16'h7FFF) begin bad++; $display("FAIL clamp_hi mask=%h required=7fff", bus.row_mask); end
        ticks(1);
        total++;
        if (bus.row_mask !== 16'hFFFE) begin bad++; $display("FAIL clamp_hi_pos1 mask=%h required=fffe", bus.row_mask); end
        ticks(1);
        total++;
        if (bus.row_mask !== 16'h7FFF) begin bad++; $display("FAIL clamp_hi_back mask=%h required=7fff", bus.row_mask); end
        do_stop("clamp_hi", 1'b0, 16'h7FFF, 4'd15);
    endtask

    task automatic test_async_reset();
        apply_reset();
        pulse_start(4'd3, 6'd1, 1'b1);
        ticks(3);
        #2 resetn = 1'b0;
        #1;
        total++;
        if (bus.row_mask !== 16'h0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_move mask=%h busy=%b required mask=0 busy=0", bus.row_mask, bus.busy);
        end
        cyc(2);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            total++;
            if (bus.next_signal !== 1'b0 || bus.fail !== 1'b0 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL rst_move_after%0d ns=%b fail=%b busy=%b required all 0", i, bus.next_signal, bus.fail, bus.busy);
            end
        end
        pulse_start(4'd3, 6'd1, 1'b1);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        cyc(1);
        #1 resetn = 1'b0;
        #1;
        total++;
        if (bus.next_signal !== 1'b0 || bus.busy !== 1'b0 || bus.kept_blocks !== 4'd0) begin
            bad++; $display("FAIL rst_report ns=%b busy=%b kept=%0d required ns=0 busy=0 kept=0", bus.next_signal, bus.busy, bus.kept_blocks);
        end
        cyc(2);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            total++;
            if (bus.next_signal !== 1'b0 || bus.fail !== 1'b0 || bus.row_mask !== 16'h0) begin
                bad++; $display("FAIL rst_report_after%0d ns=%b fail=%b mask=%h required 0", i, bus.next_signal, bus.fail, bus.row_mask);
            end
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.first_row = 1'b0;
        bus.speed_count = '0; bus.num_blocks = '0;
        test_reset();
        test_bounce();
        test_speed();
        test_keep();
        test_fail();
        test_stop_clamp();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
